// File: rtl/timer_arbiter.sv
// ---------------------------------------------------------------------------
// timer_arbiter
//
// Shares one minute-scaled delay timer among N_REQ requesters. It grants the
// single tick/minute counter round-robin and pulses the owner's done once the
// latched number of design-minutes has elapsed.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   asynchronous, active-low reset
//   req       in   [N_REQ]        level request per requester
//   dur       in   [N_REQ*DUR_W]  requested minutes, requester i at [i*DUR_W +: DUR_W]
//   abort     in   cancels the running timing without a done pulse
//   grant     out  [N_REQ]        one-hot owner indication while timing
//   done      out  [N_REQ]        one-cycle pulse to the owner on completion
//   busy      out  high while the timer is owned (RUN or DONE)
//   min_left  out  [DUR_W]        minutes remaining, 0 when idle
// ---------------------------------------------------------------------------
module timer_arbiter #(
  parameter int N_REQ         = 4,
  parameter int DUR_W         = 4,
  parameter int CLOCK         = 25000000,
  parameter int TICKS_PER_MIN = CLOCK / 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*DUR_W-1:0] dur,
  input  logic                   abort,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [DUR_W-1:0]       min_left
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int TICK_W = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_MIN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   owner, owner_next;
  logic [IDX_W-1:0]   ptr, ptr_next;
  logic [DUR_W-1:0]   min_q, min_next;
  logic [TICK_W-1:0]  tick_cnt, tick_next;

  // Round-robin winner search, starting one past the last served requester.
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   cand;
  logic [DUR_W-1:0]   win_dur;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    win_dur = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_idx == IDX_W'(i)) win_dur = dur[i*DUR_W +: DUR_W];
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    owner_next = owner;
    ptr_next   = ptr;
    min_next   = min_q;
    tick_next  = tick_cnt;
    case (state)
      IDLE: begin
        if (win_found) begin
          owner_next = win_idx;
          // A zero duration still costs one minute so every grant ends in done.
          min_next   = (win_dur == '0) ? DUR_W'(1) : win_dur;
          tick_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        // abort outranks the minute expiry in the same cycle.
        if (abort) begin
          state_next = IDLE;
          min_next   = '0;
          tick_next  = '0;
          ptr_next   = owner;
        end else if (tick_cnt == TICK_LAST) begin
          tick_next = '0;
          min_next  = min_q - DUR_W'(1);
          if (min_q == DUR_W'(1)) state_next = DONE;
        end else begin
          tick_next = tick_cnt + TICK_W'(1);
        end
      end
      DONE: begin
        ptr_next   = owner;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: asynchronous reset clears every state register so outputs drop at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      owner    <= '0;
      ptr      <= IDX_W'(N_REQ - 1);
      min_q    <= '0;
      tick_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
      state    <= state_next;
      owner    <= owner_next;
      ptr      <= ptr_next;
      min_q    <= min_next;
      tick_cnt <= tick_next;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    grant = '0;
    done  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant[i] = (state == RUN)  && (owner == IDX_W'(i));
      done[i]  = (state == DONE) && (owner == IDX_W'(i));
    end
  end

  assign busy     = (state != IDLE);
  assign min_left = min_q;

endmodule
